dmem_arbiter: RTL and testbench

- Shares the single data-RAM port between the pipeline MEM stage (CPU) and a DMA/loader requester (e.g. the UART program/data loader).
- CPU has default priority. DMA wins either after a starvation limit or while it holds an active burst.
- Raises cpu_stall so the hazard logic freezes PC, IF/ID, ID/EX and EX/MEM while the CPU is locked out.
- Sits between EX/MEM outputs and DataMem; the peripheral region is not routed through it.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle around the data-RAM arbiter.
//   cpu_*  : MEM-stage requester (rd/wr/addr/wdata in, rdata/stall out)
//   dma_*  : DMA/loader requester (req/wr/addr/wdata in, gnt/rvalid/rdata/err out)
//   mem_*  : single DataMem port (rd/wr/addr/wdata out, rdata in)
// modport slave is the arbiter's view; modport master is the environment's view.
interface dmem_arb_if;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dma_req;
    logic        dma_wr;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [31:0] dma_rdata;
    logic        dma_err;

    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dma_req, dma_wr, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata, dma_err,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dma_req, dma_wr, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_err,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-RAM port between the MEM stage (CPU)
// and a DMA/loader requester. CPU has default priority; DMA is forced in
// after STARVE_MAX denied cycles and then keeps the port for up to
// BURST_LEN consecutive grants.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_arb_if.slave (cpu_*, dma_*, mem_* signal groups)
//   stall_cycles, dma_cycles : activity counters, only with DMEM_ARB_STATS_EN
// Optional feature macro: DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int BURST_LEN  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    dmem_arb_if.slave   bus
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] dma_cycles
`endif
);
    localparam logic [0:0] S_CPU = 1'b0;
    localparam logic [0:0] S_DMA = 1'b1;
    localparam logic [3:0] BL    = 4'(BURST_LEN);
    localparam logic [7:0] SM    = 8'(STARVE_MAX);

    logic [0:0] state;
    logic [3:0] burst_cnt;
    logic [7:0] starve_cnt;

    logic cpu_req, dma_cont, dma_force, dma_win, cpu_win, dma_ok;

    always_comb begin
        cpu_req   = bus.cpu_rd | bus.cpu_wr;
        // Burst continuation takes precedence; once it ends, the CPU-state
        // rules are evaluated in the same cycle.
        dma_cont  = (state == S_DMA) && bus.dma_req && (burst_cnt < BL);
        dma_force = !dma_cont && bus.dma_req && (!cpu_req || starve_cnt == SM);
        dma_win   = (dma_cont || dma_force) && !reset;
        cpu_win   = !dma_cont && !dma_force && cpu_req && !reset;
        // Peripheral window (0x4xxxxxxx) and upper half are not RAM.
        dma_ok    = !((bus.dma_addr[31:28] == 4'b0100) || bus.dma_addr[31]);
    end

    always_comb begin
        bus.mem_rd    = 1'b0;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        if (cpu_win) begin
            bus.mem_rd    = bus.cpu_rd;
            bus.mem_wr    = bus.cpu_wr;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (dma_win && dma_ok) begin
            bus.mem_rd    = !bus.dma_wr;
            bus.mem_wr    = bus.dma_wr;
            bus.mem_addr  = bus.dma_addr;
            bus.mem_wdata = bus.dma_wdata;
        end
    end

    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.cpu_stall = cpu_req && !cpu_win;
    // Rejected (out-of-range) DMA accesses still consume the grant.
    assign bus.dma_gnt   = dma_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_CPU;
            burst_cnt      <= 4'd0;
            starve_cnt     <= 8'd0;
            bus.dma_rvalid <= 1'b0;
            bus.dma_rdata  <= 32'h0;
            bus.dma_err    <= 1'b0;
        end else begin
            if (dma_cont) begin
                burst_cnt <= burst_cnt + 4'd1;
            end else if (dma_force) begin
                state      <= S_DMA;
                burst_cnt  <= 4'd1;
                starve_cnt <= 8'd0;
            end else begin
                state     <= S_CPU;
                burst_cnt <= 4'd0;
                if (cpu_req && bus.dma_req)
                    starve_cnt <= (starve_cnt == SM) ? SM : starve_cnt + 8'd1;
                else
                    starve_cnt <= 8'd0;
            end
            bus.dma_rvalid <= dma_win && dma_ok && !bus.dma_wr;
            bus.dma_err    <= dma_win && !dma_ok;
            if (dma_win && dma_ok && !bus.dma_wr)
                bus.dma_rdata <= bus.mem_rdata;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'h0;
            dma_cycles   <= 32'h0;
        end else begin
            if (bus.cpu_stall) stall_cycles <= stall_cycles + 32'd1;
            if (bus.dma_gnt)   dma_cycles   <= dma_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench. The stimulus process drives one cycle at
// a time, predicts the outputs from a counter-based model of the priority
// rules and queues them; a negedge monitor pops and compares.
module tb_dmem_arbiter;
    localparam int BURST_LEN  = 4;
    localparam int STARVE_MAX = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arb_if bus();

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cycles, dma_cycles;
`endif

    dmem_arbiter #(.BURST_LEN(BURST_LEN), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .dma_cycles(dma_cycles)
`endif
    );

    // DataMem: 256 words, combinational read, write at clk edge.
    logic [31:0] ram [256];
    logic        poke_en;
    logic [7:0]  poke_idx;
    logic [31:0] poke_data;
    assign bus.mem_rdata = ram[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (poke_en) ram[poke_idx] <= poke_data;
        else if (bus.mem_wr) ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end

    typedef struct {
        bit          rst;
        bit          mem_rd, mem_wr;
        logic [31:0] mem_addr, mem_wdata, cpu_rdata;
        bit          cpu_stall, dma_gnt, rvalid, err;
        logic [31:0] rdata;
    } exp_t;
    exp_t expq[$];

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("mem_rd", 32'(bus.mem_rd), 32'(e.mem_rd));
            chk("mem_wr", 32'(bus.mem_wr), 32'(e.mem_wr));
            if (!e.rst) begin
                chk("mem_addr",   bus.mem_addr,  e.mem_addr);
                chk("mem_wdata",  bus.mem_wdata, e.mem_wdata);
                chk("cpu_rdata",  bus.cpu_rdata, e.cpu_rdata);
                chk("cpu_stall",  32'(bus.cpu_stall),  32'(e.cpu_stall));
                chk("dma_gnt",    32'(bus.dma_gnt),    32'(e.dma_gnt));
                chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(e.rvalid));
                chk("dma_err",    32'(bus.dma_err),    32'(e.err));
                chk("dma_rdata",  bus.dma_rdata, e.rdata);
            end
        end
    end

    // Requester state driven each cycle
    bit          c_rd, c_wr, d_req, d_wr;
    logic [31:0] c_addr, c_wd, d_addr, d_wd;
    bit          last_dgnt;

    // Reference model state
    logic [31:0] ref_mem [256];
    int          starved, beats;
    bit          m_rv, m_err;
    logic [31:0] m_rd;

    task automatic do_cycle(input bit rst);
        exp_t e;
        bit cpu_req, dwin, cwin, legal;
        @(posedge clk); #1;
        reset         = rst;
        bus.cpu_rd    = c_rd;   bus.cpu_wr   = c_wr;
        bus.cpu_addr  = c_addr; bus.cpu_wdata = c_wd;
        bus.dma_req   = d_req;  bus.dma_wr   = d_wr;
        bus.dma_addr  = d_addr; bus.dma_wdata = d_wd;

        cpu_req = c_rd | c_wr;
        legal   = !((d_addr[31:28] == 4'h4) || d_addr[31]);
        dwin = 0; cwin = 0;
        if (rst) begin
            starved = 0; beats = 0;
        end else if (d_req && beats > 0 && beats < BURST_LEN) begin
            dwin = 1; beats++;
        end else begin
            beats = 0;
            if (d_req && (!cpu_req || starved >= STARVE_MAX)) begin
                dwin = 1; beats = 1; starved = 0;
            end else if (cpu_req) begin
                cwin = 1;
                starved = d_req ? ((starved < STARVE_MAX) ? starved + 1 : STARVE_MAX) : 0;
            end else begin
                starved = 0;
            end
        end

        e.rst = rst;
        e.mem_rd = 0; e.mem_wr = 0; e.mem_addr = 0; e.mem_wdata = 0;
        if (cwin) begin
            e.mem_rd = c_rd; e.mem_wr = c_wr; e.mem_addr = c_addr; e.mem_wdata = c_wd;
        end else if (dwin && legal) begin
            e.mem_rd = !d_wr; e.mem_wr = d_wr; e.mem_addr = d_addr; e.mem_wdata = d_wd;
        end
        e.cpu_rdata = ref_mem[e.mem_addr[9:2]];
        e.cpu_stall = cpu_req && !cwin;
        e.dma_gnt   = dwin;
        e.rvalid    = m_rv;
        e.rdata     = m_rd;
        e.err       = m_err;
        expq.push_back(e);

        if (rst) begin
            m_rv = 0; m_err = 0; m_rd = 0;
        end else begin
            m_rv  = dwin && legal && !d_wr;
            m_err = dwin && !legal;
            if (m_rv) m_rd = ref_mem[d_addr[9:2]];
        end
        if (poke_en) ref_mem[poke_idx] = poke_data;
        else if (e.mem_wr) ref_mem[e.mem_addr[9:2]] = e.mem_wdata;
        last_dgnt = dwin;
    endtask

    task automatic idle_all();
        c_rd = 0; c_wr = 0; c_addr = 0; c_wd = 0;
        d_req = 0; d_wr = 0; d_addr = 0; d_wd = 0;
    endtask

    initial begin
        logic [31:0] ov;
        idle_all();
        poke_en = 0; poke_idx = 0; poke_data = 0;
        starved = 0; beats = 0; m_rv = 0; m_err = 0; m_rd = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        reset = 1;
        bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_wr = 0; bus.dma_addr = 0; bus.dma_wdata = 0;

        // Preload RAM while in reset
        for (int i = 0; i < 256; i++) begin
            poke_en = 1; poke_idx = 8'(i);
            poke_data = (i == 8) ? 32'hDEADBEEF : $urandom;
            do_cycle(1);
        end
        poke_en = 0;
        do_cycle(1);

        // Reset state
        @(negedge clk); #1;
        chk("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
        chk("rst_dma_err",    32'(bus.dma_err), 32'h0);
        chk("rst_dma_rdata",  bus.dma_rdata, 32'h0);

        // CPU reads 0x10 continuously, DMA idle
        c_rd = 1; c_addr = 32'h10;
        for (int k = 0; k < 10; k++) do_cycle(0);

        // CPU idle, DMA read 0x20
        idle_all();
        d_req = 1; d_addr = 32'h20;
        do_cycle(0);
        d_req = 0;
        do_cycle(0);
        @(negedge clk); #1;
        chk("dma_rd_rvalid", 32'(bus.dma_rvalid), 32'h1);
        chk("dma_rd_rdata",  bus.dma_rdata, 32'hDEADBEEF);
        do_cycle(0);

        // Starvation: CPU continuous, DMA held from cycle 0
        c_rd = 1; c_addr = 32'h10;
        d_req = 1; d_addr = 32'h30;
        for (int k = 0; k < 16; k++) begin
            do_cycle(0);
            @(negedge clk); #1;
            chk($sformatf("starve_gnt_c%0d", k), 32'(bus.dma_gnt), 32'(k >= 8 && k < 12));
            chk($sformatf("starve_stall_c%0d", k), 32'(bus.cpu_stall), 32'(k >= 8 && k < 12));
        end
        idle_all();
        do_cycle(0); do_cycle(0);

        // DMA write then CPU read of the same word
        d_req = 1; d_wr = 1; d_addr = 32'h4; d_wd = 32'h12345678;
        do_cycle(0);
        idle_all();
        c_rd = 1; c_addr = 32'h4;
        do_cycle(0);
        @(negedge clk); #1;
        chk("wr_then_rd", bus.cpu_rdata, 32'h12345678);

        // Illegal DMA address
        idle_all();
        d_req = 1; d_addr = 32'h4000000C;
        do_cycle(0);
        @(negedge clk); #1;
        chk("bad_gnt",   32'(bus.dma_gnt), 32'h1);
        chk("bad_mem_rd", 32'(bus.mem_rd), 32'h0);
        idle_all();
        do_cycle(0);
        @(negedge clk); #1;
        chk("bad_err",    32'(bus.dma_err), 32'h1);
        chk("bad_rvalid", 32'(bus.dma_rvalid), 32'h0);

        // Reset on the second beat of a burst
        d_req = 1; d_addr = 32'h24;
        do_cycle(0);
        c_rd = 1; c_addr = 32'h10; d_addr = 32'h28;
        do_cycle(1);
        do_cycle(0);
        @(negedge clk); #1;
        chk("post_rst_stall",  32'(bus.cpu_stall), 32'h0);
        chk("post_rst_rvalid", 32'(bus.dma_rvalid), 32'h0);
        idle_all();
        do_cycle(0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            int r;
            r = $urandom_range(0, 9);
            c_rd = (r < 4); c_wr = (r >= 4 && r < 6);
            c_addr = {22'h0, 8'($urandom), 2'b00};
            c_wd = $urandom;
            if (!d_req || last_dgnt) begin
                d_req = ($urandom_range(0, 9) < 5);
                d_wr = $urandom_range(0, 1) == 1;
                d_wd = $urandom;
                case ($urandom_range(0, 9))
                    0:       d_addr = 32'h40000000 | {22'h0, 8'($urandom), 2'b00};
                    1:       d_addr = 32'h80000000 | {22'h0, 8'($urandom), 2'b00};
                    default: d_addr = {22'h0, 8'($urandom), 2'b00};
                endcase
            end
            do_cycle($urandom_range(0, 299) == 0);
        end
        idle_all();
        do_cycle(0);

        for (int w = 0; w < 5 && expq.size() > 0; w++) @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
